// File: rtl/beat_bus_ctrl_pkg.sv
// Shared definitions for the beat sequencer / bus controller:
// opcodes, FSM state type, registered bus bundle and opcode classifiers.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F_HI,
    S_F_LO,
    S_EX,
    S_MEM,
    S_WB
  } state_e;

  localparam logic [3:0] OP_JMP = 4'h0;
  localparam logic [3:0] OP_JZ  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_MOI = 4'h4;
  localparam logic [3:0] OP_MOV = 4'h5;
  localparam logic [3:0] OP_STA = 4'h6;
  localparam logic [3:0] OP_LDA = 4'h7;
  localparam logic [3:0] OP_OUT = 4'h8;
  localparam logic [3:0] OP_IN  = 4'h9;

  localparam logic [3:0] BEAT_T1 = 4'b0001;
  localparam logic [3:0] BEAT_T2 = 4'b0010;
  localparam logic [3:0] BEAT_T3 = 4'b0100;
  localparam logic [3:0] BEAT_T4 = 4'b1000;

  typedef struct packed {
    logic [3:0] beat;
    logic [7:0] abus;
    logic [1:0] ioad;
    logic       nmreq;
    logic       nrd;
    logic       nwr;
    logic       npreq;
    logic       nprd;
    logic       npwr;
    logic       oe;
  } bus_out_t;

  localparam bus_out_t BUS_IDLE = '{
    beat:  4'b0000,
    abus:  8'h00,
    ioad:  2'b00,
    nmreq: 1'b1,
    nrd:   1'b1,
    nwr:   1'b1,
    npreq: 1'b1,
    nprd:  1'b1,
    npwr:  1'b1,
    oe:    1'b0
  };

  function automatic logic is_mem_op(input logic [3:0] op);
    return op inside {OP_STA, OP_LDA, OP_OUT, OP_IN};
  endfunction

  function automatic logic is_wb_op(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MOI, OP_MOV, OP_LDA, OP_IN};
  endfunction

  function automatic logic is_jmp_op(input logic [3:0] op);
    return op inside {OP_JMP, OP_JZ};
  endfunction

endpackage

// File: rtl/beat_bus_ctrl_if.sv
// Shared external bus: memory and port strobes, address, port id,
// data-bus enable and the slave ready return.
interface beat_bus_ctrl_if;
  logic [7:0] ABUS;
  logic [1:0] IOAD;
  logic       nMREQ;
  logic       nRD;
  logic       nWR;
  logic       nPREQ;
  logic       nPRD;
  logic       nPWR;
  logic       dbus_oe;
  logic       rdy;

  modport master (
    output ABUS, IOAD,
    output nMREQ, nRD, nWR,
    output nPREQ, nPRD, nPWR,
    output dbus_oe,
    input  rdy
  );

  modport slave (
    input  ABUS, IOAD,
    input  nMREQ, nRD, nWR,
    input  nPREQ, nPRD, nPWR,
    input  dbus_oe,
    output rdy
  );
endinterface

// File: rtl/beat_bus_ctrl_timer.sv
// Ready-wait counter for bus accesses; expired marks the rdy=0
// cycle that brings the count to its maximum of 2^WAIT_W-1.
module bus_wait_timer #(
  parameter int WAIT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LAST =
    {{(WAIT_W-1){1'b1}}, 1'b0};

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/beat_bus_ctrl.sv
// Instruction-cycle sequencer: one-hot beats, two-byte fetch,
// memory/port handshakes and datapath strobes with access timeout.
module beat_bus_ctrl
  import cpu_pkg::*;
#(
  parameter int WAIT_W = 4
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             run,
  input  logic [15:0]      ir,
  input  logic [7:0]       pc,
  input  logic             jp,
  beat_bus_ctrl_if.master  bus,
  output logic [3:0]       beat,
  output logic             ir_ld_hi,
  output logic             ir_ld_lo,
  output logic             pc_inc,
  output logic             pc_ld,
  output logic             wbin,
  output logic             wbr,
  output logic             bus_err
);

  state_e   state;
  state_e   state_n;
  bus_out_t bq;
  bus_out_t bn;
  logic [3:0] op;
  logic [7:0] fa;
  logic       acc;
  logic       rdy;
  logic       expired;
  logic       tmr_en;
  logic       tmr_clr;
  logic       jump;
  logic       err_n;
  logic       unused_ir;

  assign op        = ir[15:12];
  assign rdy       = bus.rdy;
  assign unused_ir = ^ir[11:8];

  assign acc = (state == S_F_HI) ||
               (state == S_F_LO) ||
               (state == S_MEM);

  assign tmr_en  = acc && !rdy;
  assign tmr_clr = !acc || (state_n != state);

  bus_wait_timer #(
    .WAIT_W (WAIT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (nRST),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );

  assign jump  = (state == S_WB) && is_jmp_op(op) && jp;
  assign err_n = bus_err || expired;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (run && !bus_err) state_n = S_F_HI;
      S_F_HI: begin
        if (rdy)          state_n = S_F_LO;
        else if (expired) state_n = S_IDLE;
      end
      S_F_LO: begin
        if (rdy)          state_n = S_EX;
        else if (expired) state_n = S_IDLE;
      end
      S_EX: state_n = is_mem_op(op) ? S_MEM : S_WB;
      S_MEM: begin
        if (rdy)          state_n = S_WB;
        else if (expired) state_n = S_IDLE;
      end
      S_WB: state_n = run ? S_F_HI : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Fetch address anticipates the PC register update made on this edge.
  always_comb begin
    fa = pc;
    unique case (1'b1)
      (state == S_F_HI) && rdy: fa = pc + 8'd1;
      jump:                     fa = ir[7:0];
      default:                  fa = pc;
    endcase
  end

  always_comb begin
    bn = BUS_IDLE;
    unique case (state_n)
      S_F_HI, S_F_LO: begin
        bn.beat  = BEAT_T1;
        bn.abus  = fa;
        bn.nmreq = 1'b0;
        bn.nrd   = 1'b0;
      end
      S_EX: bn.beat = BEAT_T2;
      S_MEM: begin
        bn.beat = BEAT_T3;
        unique case (op)
          OP_STA: begin
            bn.abus  = ir[7:0];
            bn.nmreq = 1'b0;
            bn.nwr   = 1'b0;
            bn.oe    = 1'b1;
          end
          OP_LDA: begin
            bn.abus  = ir[7:0];
            bn.nmreq = 1'b0;
            bn.nrd   = 1'b0;
          end
          OP_OUT: begin
            bn.ioad  = ir[1:0];
            bn.npreq = 1'b0;
            bn.npwr  = 1'b0;
            bn.oe    = 1'b1;
          end
          OP_IN: begin
            bn.ioad  = ir[1:0];
            bn.npreq = 1'b0;
            bn.nprd  = 1'b0;
          end
          default: bn = BUS_IDLE;
        endcase
      end
      S_WB:    bn.beat = BEAT_T4;
      default: bn = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state   <= S_IDLE;
      bq      <= BUS_IDLE;
      bus_err <= 1'b0;
    end else begin
      state   <= state_n;
      bq      <= bn;
      bus_err <= err_n;
    end
  end

  assign beat        = bq.beat;
  assign bus.ABUS    = bq.abus;
  assign bus.IOAD    = bq.ioad;
  assign bus.nMREQ   = bq.nmreq;
  assign bus.nRD     = bq.nrd;
  assign bus.nWR     = bq.nwr;
  assign bus.nPREQ   = bq.npreq;
  assign bus.nPRD    = bq.nprd;
  assign bus.nPWR    = bq.npwr;
  assign bus.dbus_oe = bq.oe;

  assign ir_ld_hi = (state == S_F_HI) && rdy;
  assign ir_ld_lo = (state == S_F_LO) && rdy;
  assign pc_inc   = ((state == S_F_HI) ||
                     (state == S_F_LO)) && rdy;
  assign wbin     = (state == S_MEM) && rdy &&
                    ((op == OP_LDA) || (op == OP_IN));
  assign wbr      = (state == S_WB) && is_wb_op(op);
  assign pc_ld    = jump;

endmodule

// File: tb/tb_beat_bus_ctrl.sv
// Bench: instruction-level expected-cycle model vs beat_bus_ctrl,
// randomized opcodes/waits plus directed fetch, memory, port and timeout cases.
module tb_beat_bus_ctrl;

  typedef struct {
    logic        run;
    logic        rdy;
    logic        jp;
    logic [15:0] ir;
    logic [7:0]  pc;
    logic [3:0]  beat;
    logic [7:0]  abus;
    logic [1:0]  ioad;
    logic [5:0]  n;
    logic        oe;
    logic [5:0]  s;
    logic        err;
  } cyc_t;

  localparam logic [5:0] N_IDLE = 6'b111111;
  localparam logic [5:0] N_MRD  = 6'b001111;
  localparam logic [5:0] N_MWR  = 6'b010111;
  localparam logic [5:0] N_PRD  = 6'b111001;
  localparam logic [5:0] N_PWR  = 6'b111010;
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_HI   = 6'b101000;
  localparam logic [5:0] S_LO   = 6'b011000;
  localparam logic [5:0] S_PCLD = 6'b000100;
  localparam logic [5:0] S_WBIN = 6'b000010;
  localparam logic [5:0] S_WBR  = 6'b000001;

  logic        clk = 1'b0;
  logic        nRST;
  logic        run;
  logic        jp;
  logic [15:0] ir;
  logic [7:0]  pc;
  logic [3:0]  beat;
  logic        ir_ld_hi, ir_ld_lo, pc_inc, pc_ld, wbin, wbr;
  logic        bus_err;

  beat_bus_ctrl_if bus ();

  beat_bus_ctrl #(
    .WAIT_W (4)
  ) dut (
    .clk      (clk),
    .nRST     (nRST),
    .run      (run),
    .ir       (ir),
    .pc       (pc),
    .jp       (jp),
    .bus      (bus),
    .beat     (beat),
    .ir_ld_hi (ir_ld_hi),
    .ir_ld_lo (ir_ld_lo),
    .pc_inc   (pc_inc),
    .pc_ld    (pc_ld),
    .wbin     (wbin),
    .wbr      (wbr),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  cyc_t        q[$];
  cyc_t        obs[$];
  int          vecs = 0;
  int          errs = 0;
  int          cyc  = 0;
  logic [7:0]  mpc;
  logic        merr;
  logic        cur_run;
  logic        cur_jp;
  logic [15:0] cur_ir;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] b, input logic [7:0] a,
                     input logic [1:0] io, input logic [5:0] n,
                     input logic oe, input logic [5:0] s,
                     input logic rdy);
    cyc_t e;
    e.run = cur_run; e.rdy = rdy; e.jp = cur_jp;
    e.ir = cur_ir; e.pc = mpc;
    e.beat = b; e.abus = a; e.ioad = io; e.n = n;
    e.oe = oe; e.s = s; e.err = merr;
    q.push_back(e);
  endtask

  task automatic idle_c(input logic r);
    cur_run = r;
    add(4'b0, 8'h0, 2'b0, N_IDLE, 1'b0, S_NONE, 1'($urandom));
  endtask

  // An access: w cycles without rdy, then the completing rdy cycle;
  // fifteen silent cycles abort the access instead.
  task automatic access(input logic [3:0] b, input logic [7:0] a,
                        input logic [1:0] io, input logic [5:0] n,
                        input logic oe, input logic [5:0] sd,
                        input int w, output bit ok);
    int k;
    k = (w > 15) ? 15 : w;
    for (int i = 0; i < k; i++) add(b, a, io, n, oe, S_NONE, 1'b0);
    if (w >= 15) begin
      ok = 0;
      merr = 1'b1;
    end else begin
      add(b, a, io, n, oe, sd, 1'b1);
      ok = 1;
    end
  endtask

  task automatic instr(input logic [15:0] iw, input logic j,
                       input int w1, input int w2, input int w3,
                       input logic rmid, input logic rend,
                       output bit ok);
    logic [3:0] op;
    logic [5:0] s;
    op = iw[15:12];
    cur_ir = iw; cur_jp = j; cur_run = 1'b1;
    access(4'b0001, mpc, 2'b0, N_MRD, 1'b0, S_HI, w1, ok);
    if (!ok) return;
    mpc++;
    cur_run = rmid;
    access(4'b0001, mpc, 2'b0, N_MRD, 1'b0, S_LO, w2, ok);
    if (!ok) return;
    mpc++;
    add(4'b0010, 8'h0, 2'b0, N_IDLE, 1'b0, S_NONE, 1'($urandom));
    ok = 1;
    case (op)
      4'h6: access(4'b0100, iw[7:0], 2'b0, N_MWR, 1'b1, S_NONE, w3, ok);
      4'h7: access(4'b0100, iw[7:0], 2'b0, N_MRD, 1'b0, S_WBIN, w3, ok);
      4'h8: access(4'b0100, 8'h0, iw[1:0], N_PWR, 1'b1, S_NONE, w3, ok);
      4'h9: access(4'b0100, 8'h0, iw[1:0], N_PRD, 1'b0, S_WBIN, w3, ok);
      default: ok = 1;
    endcase
    if (!ok) return;
    cur_run = rend;
    s = S_NONE;
    if (op inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h9}) s = S_WBR;
    if ((op inside {4'h0, 4'h1}) && j) s = S_PCLD;
    add(4'b1000, 8'h0, 2'b0, N_IDLE, 1'b0, s, 1'($urandom));
    if (s == S_PCLD) mpc = iw[7:0];
  endtask

  task automatic sample(output cyc_t o);
    o.run = run; o.rdy = bus.rdy; o.jp = jp; o.ir = ir; o.pc = pc;
    o.beat = beat; o.abus = bus.ABUS; o.ioad = bus.IOAD;
    o.n = {bus.nMREQ, bus.nRD, bus.nWR, bus.nPREQ, bus.nPRD, bus.nPWR};
    o.oe = bus.dbus_oe;
    o.s = {ir_ld_hi, ir_ld_lo, pc_inc, pc_ld, wbin, wbr};
    o.err = bus_err;
  endtask

  task automatic run_q();
    cyc_t e;
    cyc_t o;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(posedge clk);
      #1;
      run = e.run; bus.rdy = e.rdy; jp = e.jp; ir = e.ir; pc = e.pc;
      @(negedge clk);
      cyc++;
      sample(o);
      obs.push_back(o);
      chk("beat", 16'(o.beat), 16'(e.beat));
      chk("abus", 16'(o.abus), 16'(e.abus));
      chk("ioad", 16'(o.ioad), 16'(e.ioad));
      chk("nstb", 16'(o.n), 16'(e.n));
      chk("dbus_oe", 16'(o.oe), 16'(e.oe));
      chk("dstb", 16'(o.s), 16'(e.s));
      chk("bus_err", 16'(o.err), 16'(e.err));
    end
  endtask

  task automatic do_reset();
    cyc_t o;
    nRST = 1'b0; run = 1'b0; bus.rdy = 1'b0; jp = 1'b0;
    ir = 16'h0; pc = 8'h0;
    repeat (2) @(negedge clk);
    sample(o);
    chk("rst_beat", 16'(o.beat), 16'h0);
    chk("rst_abus", 16'(o.abus), 16'h0);
    chk("rst_ioad", 16'(o.ioad), 16'h0);
    chk("rst_nstb", 16'(o.n), 16'(N_IDLE));
    chk("rst_oe", 16'(o.oe), 16'h0);
    chk("rst_dstb", 16'(o.s), 16'h0);
    chk("rst_err", 16'(o.err), 16'h0);
    nRST = 1'b1;
    merr = 1'b0;
    obs.delete();
  endtask

  initial begin
    bit ok;
    int n;
    cyc_t o;

    do_reset();

    // JMP with jp=1 from pc 0x10
    mpc = 8'h10;
    idle_c(1'b1);
    instr(16'h0000, 1'b1, 0, 0, 0, 1'b1, 1'b0, ok);
    idle_c(1'b0);
    chk("jmp_model_len", 16'(q.size()), 16'd6);
    run_q();
    chk("jmp_b1", 16'(obs[1].beat), 16'h1);
    chk("jmp_b2", 16'(obs[2].beat), 16'h1);
    chk("jmp_b3", 16'(obs[3].beat), 16'h2);
    chk("jmp_b4", 16'(obs[4].beat), 16'h8);
    chk("jmp_a1", 16'(obs[1].abus), 16'h10);
    chk("jmp_a2", 16'(obs[2].abus), 16'h11);
    chk("jmp_pcld", 16'(obs[4].s[2]), 16'h1);

    // STA zero-wait
    obs.delete();
    mpc = 8'h20;
    idle_c(1'b1);
    instr(16'h6003, 1'b0, 0, 0, 0, 1'b1, 1'b0, ok);
    idle_c(1'b0);
    run_q();
    chk("sta_beat", 16'(obs[4].beat), 16'h4);
    chk("sta_abus", 16'(obs[4].abus), 16'h03);
    chk("sta_nstb", 16'(obs[4].n), 16'(N_MWR));
    chk("sta_oe", 16'(obs[4].oe), 16'h1);
    chk("sta_wbr", 16'(obs[5].s[0]), 16'h0);
    chk("sta_done", 16'(obs[6].beat), 16'h0);

    // IN with three wait cycles
    obs.delete();
    mpc = 8'h30;
    idle_c(1'b1);
    instr(16'h9003, 1'b0, 0, 0, 3, 1'b1, 1'b0, ok);
    idle_c(1'b0);
    run_q();
    for (int i = 4; i < 8; i++) begin
      chk("in_nstb", 16'(obs[i].n), 16'(N_PRD));
      chk("in_ioad", 16'(obs[i].ioad), 16'h3);
      chk("in_wbin", 16'(obs[i].s[1]), 16'(i == 7));
    end
    chk("in_wbr", 16'(obs[8].s[0]), 16'h1);

    // NOP opcode
    obs.delete();
    mpc = 8'h40;
    idle_c(1'b1);
    instr(16'hA0FF, 1'b1, 0, 0, 0, 1'b1, 1'b0, ok);
    idle_c(1'b0);
    run_q();
    chk("nop_ex", 16'(obs[3].beat), 16'h2);
    chk("nop_wb", 16'(obs[4].beat), 16'h8);
    chk("nop_dstb", 16'(obs[4].s), 16'h0);
    chk("nop_done", 16'(obs[5].beat), 16'h0);

    // randomized instruction stream
    obs.delete();
    mpc = 8'($urandom);
    idle_c(1'b1);
    n = 60;
    for (int i = 0; i < n; i++) begin
      logic rend;
      rend = (i == n - 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      instr(16'($urandom), 1'($urandom),
            ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
            ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
            ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0,
            1'($urandom), rend, ok);
      if (!rend && i != n - 1) begin
        for (int k = 0; k < $urandom_range(0, 2); k++) idle_c(1'b0);
        idle_c(1'b1);
      end
    end
    idle_c(1'b0);
    run_q();

    // fetch timeout, stays idle while run=1
    do_reset();
    mpc = 8'h50;
    idle_c(1'b1);
    instr(16'h2000, 1'b0, 15, 0, 0, 1'b1, 1'b1, ok);
    for (int i = 0; i < 5; i++) idle_c(1'b1);
    run_q();
    chk("to_last_beat", 16'(obs[15].beat), 16'h1);
    chk("to_last_err", 16'(obs[15].err), 16'h0);
    chk("to_err", 16'(obs[16].err), 16'h1);
    chk("to_nstb", 16'(obs[16].n), 16'(N_IDLE));
    chk("to_stay", 16'(obs[20].beat), 16'h0);

    // memory-phase timeout on LDA
    do_reset();
    mpc = 8'h60;
    idle_c(1'b1);
    instr(16'h7055, 1'b0, 1, 0, 20, 1'b1, 1'b1, ok);
    for (int i = 0; i < 4; i++) idle_c(1'b1);
    run_q();

    // reset asserted during LDA memory read
    do_reset();
    mpc = 8'h70;
    idle_c(1'b1);
    cur_ir = 16'h7042; cur_jp = 1'b0; cur_run = 1'b1;
    add(4'b0001, mpc, 2'b0, N_MRD, 1'b0, S_HI, 1'b1);
    mpc++;
    add(4'b0001, mpc, 2'b0, N_MRD, 1'b0, S_LO, 1'b1);
    mpc++;
    add(4'b0010, 8'h0, 2'b0, N_IDLE, 1'b0, S_NONE, 1'b0);
    run_q();
    @(posedge clk);
    #1 bus.rdy = 1'b0;
    @(negedge clk);
    chk("lda_mem_beat", 16'(beat), 16'h4);
    chk("lda_mem_nrd", 16'({bus.nMREQ, bus.nRD}), 16'h0);
    #2 bus.rdy = 1'b1;
    #1 chk("lda_wbin_pre", 16'(wbin), 16'h1);
    nRST = 1'b0;
    #1;
    chk("arst_nrd", 16'({bus.nMREQ, bus.nRD}), 16'h3);
    chk("arst_beat", 16'(beat), 16'h0);
    chk("arst_wbin", 16'(wbin), 16'h0);
    sample(o);
    chk("arst_dstb", 16'(o.s), 16'h0);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/beat_bus_ctrl.md
# beat_bus_ctrl

Instruction-cycle sequencer and external-bus controller for the 8-bit CPU. It generates the one-hot beat strobes t1–t4 that step the datapath: fetch, execute, memory, writeback. It runs the two-byte instruction fetch and drives the memory (LDA/STA) and port (IN/OUT) handshakes on the shared bus. It also issues the IR-load, PC, writeback and data-latch strobes consumed by the ALU/register datapath.

## Interface
- WAIT_W, 4, width of the ready-wait counter; an access times out after 2^WAIT_W−1 cycles without rdy
- clk  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- run  in  1  1 = keep executing; 0 = stop in IDLE at the next instruction boundary
- ir  in  16  current instruction; opcode ir[15:12], address ir[7:0], port ir[1:0]
- pc  in  8  fetch address from PC register
- jp  in  1  branch-taken from ALU, valid in EX/WB
- rdy  in  1  slave ready, sampled while an access strobe is low
- beat  out  4  one-hot {t4,t3,t2,t1}; 0 in IDLE
- ABUS  out  8  bus address
- nMREQ, nRD, nWR  out  1 each  memory request/read/write, active low
- nPREQ, nPRD, nPWR  out  1 each  port request/read/write, active low
- IOAD  out  2  port number (ir[1:0])
- dbus_oe  out  1  datapath drives data bus (STA/OUT)
- ir_ld_hi, ir_ld_lo, pc_inc, pc_ld, wbin, wbr  out  1 each  datapath strobes
- bus_err  out  1  sticky access-timeout flag

## Operation
- States: IDLE, F_HI, F_LO, EX, MEM, WB.
- Beat mapping: t1 in F_HI/F_LO, t2 in EX, t3 in MEM, t4 in WB.
- IDLE → F_HI when run=1.
- F_HI: ABUS=pc, nMREQ=nRD=0. On a cycle with rdy=1: ir_ld_hi=1, pc_inc=1, go to F_LO.
- F_LO: same as F_HI but pulses ir_ld_lo, then goes to EX.
- EX: one cycle. Go to MEM for STA/LDA/OUT/IN, else to WB.
- MEM, STA: ABUS=ir[7:0], nMREQ=nWR=0, dbus_oe=1.
- MEM, LDA: ABUS=ir[7:0], nMREQ=nRD=0; wbin=1 on the rdy cycle.
- MEM, OUT: IOAD=ir[1:0], nPREQ=nPWR=0, dbus_oe=1.
- MEM, IN: IOAD=ir[1:0], nPREQ=nPRD=0; wbin=1 on the rdy cycle.
- MEM exits to WB on the rdy cycle.
- WB: one cycle.
  - wbr=1 for ADD, SUB, MOI, MOV, LDA, IN.
  - pc_ld=jp for JMP, JZ.
  - Next state is F_HI if run=1, else IDLE.
- Opcodes: JMP 0000, JZ 0001, ADD 0010, SUB 0011, MOI 0100, MOV 0101, STA 0110, LDA 0111, OUT 1000, IN 1001.
- Opcodes 1010–1111 execute as NOP: no MEM, no wbr, no pc_ld.
- Timeout: the wait counter clears on entry to each access state and increments each cycle rdy=0.
- When the counter reaches 2^WAIT_W−1 with rdy=0: all strobes deassert, bus_err sets, state → IDLE.
- bus_err is cleared only by nRST. While bus_err=1, IDLE does not restart even if run=1.
- Memory and port strobes are never low simultaneously. nRD and nWR are never low simultaneously.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE.
  - beat=0, ABUS=0, IOAD=0.
  - All n* outputs =1.
  - dbus_oe, all datapath strobes and bus_err =0.
- Reset mid-access: strobes release in the same instant nRST falls; no completion pulse is issued.
- Registered outputs: state, beat, ABUS, IOAD, the n* strobes, dbus_oe and bus_err all change only on clk edges.
- Combinational outputs: ir_ld_hi, ir_ld_lo, pc_inc and wbin are decoded from state & rdy. The datapath captures them on the same edge that ends the access.
- Zero-wait latency: 4 cycles for non-memory instructions, 5 cycles for STA/LDA/IN/OUT.
- Each rdy=0 cycle adds one cycle to the current access.
- rdy is ignored in EX, WB and IDLE.
- pc changes only after pc_inc; F_LO sees the incremented pc one edge after F_HI completes.
- run falling mid-instruction does not abort; the instruction completes through WB.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants OP_JMP … OP_IN
  - state encoding type
  - helper functions is_mem_op(op), is_wb_op(op)
- One sub-module, bus_wait_timer: WAIT_W counter with clr, en, and expired output.
- The remainder is a single FSM plus output decode.

## Test plan
- Reset then run=1, rdy=1, pc=0x10, ir=0x0000 (JMP), jp=1:
  - Cycles show beat 0001,0001,0010,1000.
  - ABUS=0x10 then 0x11.
  - pc_ld=1 in WB.
- STA, ir=0x6003, rdy=1:
  - MEM cycle has ABUS=0x03, nMREQ=nWR=0, dbus_oe=1, beat=0100.
  - 5 cycles total; wbr=0.
- IN, ir=0x9003, rdy held 0 for 3 MEM cycles then 1:
  - nPREQ=nPRD=0 for 4 cycles, IOAD=3.
  - wbin only on the last cycle; wbr=1 in the following WB.
- WAIT_W=4, rdy=0 forever in F_HI:
  - After 15 cycles: bus_err=1, all n* high, state IDLE.
  - Stays idle with run=1 until nRST.
- nRST pulsed low during LDA MEM: nRD and nMREQ go high immediately, no wbin pulse, beat=0.
- ir=0xA0FF (NOP): EX goes directly to WB, no MEM beat, wbr=0, pc_ld=0; 4-cycle instruction.
